// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: frames one MSB-first word per valid/ready handshake, with SCK paced by
// edge-detecting the divided clock level. Ready only in IDLE, so words are never queued.
module spi_master_ctrl #(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_CNT_W      = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_clk_div,
   input  logic [P_DATA_WIDTH-1:0] i_tx_data,
   input  logic                    i_tx_valid,
   output logic                    o_tx_ready,
   output logic [P_DATA_WIDTH-1:0] o_rx_data,
   output logic                    o_rx_valid,
   output logic                    o_spi_cs_n,
   output logic                    o_spi_sck,
   output logic                    o_spi_mosi,
   input  logic                    i_spi_miso
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD} state_t;

   localparam logic [P_CNT_W-1:0] LP_LAST_BIT = P_CNT_W'(P_DATA_WIDTH);

   state_t                  state_q,    state_d;
   logic                    div_d1_q,   div_d1_d;
   logic [P_DATA_WIDTH-1:0] tx_sh_q,    tx_sh_d;
   logic [P_DATA_WIDTH-1:0] rx_sh_q,    rx_sh_d;
   logic [P_CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
   logic                    cs_n_q,     cs_n_d;
   logic                    sck_q,      sck_d;
   logic [P_DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
   logic                    rx_valid_q, rx_valid_d;

   logic rise_ev;
   logic fall_ev;

   assign rise_ev = i_clk_div & ~div_d1_q;
   assign fall_ev = ~i_clk_div & div_d1_q;

   always_comb begin
      state_d    = state_q;
      div_d1_d   = i_clk_div;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      bit_cnt_d  = bit_cnt_q;
      cs_n_d     = cs_n_q;
      sck_d      = sck_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_tx_valid) begin
               tx_sh_d   = i_tx_data;
               rx_sh_d   = '0;
               bit_cnt_d = '0;
               cs_n_d    = 1'b0;
               state_d   = ST_SETUP;
            end
         end
         // Waiting for a falling edge gives MOSI at least half a bit of setup before SCK rises.
         ST_SETUP: begin
            if (fall_ev) begin
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (rise_ev) begin
               sck_d     = 1'b1;
               rx_sh_d   = {rx_sh_q[P_DATA_WIDTH-2:0], i_spi_miso};
               bit_cnt_d = bit_cnt_q + P_CNT_W'(1);
            end else if (fall_ev) begin
               sck_d = 1'b0;
               if (bit_cnt_q == LP_LAST_BIT) begin
                  state_d = ST_HOLD;
               end else begin
                  tx_sh_d = {tx_sh_q[P_DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         ST_HOLD: begin
            if (rise_ev) begin
               cs_n_d     = 1'b1;
               rx_data_d  = rx_sh_q;
               rx_valid_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         div_d1_q   <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         bit_cnt_q  <= '0;
         cs_n_q     <= 1'b1;
         sck_q      <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_d1_q   <= div_d1_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         bit_cnt_q  <= bit_cnt_d;
         cs_n_q     <= cs_n_d;
         sck_q      <= sck_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // The MSB of the tx shifter is the MOSI register; it is not shifted on the final fall.
   assign o_spi_mosi = tx_sh_q[P_DATA_WIDTH-1];
   assign o_tx_ready = (state_q == ST_IDLE);
   assign o_spi_cs_n = cs_n_q;
   assign o_spi_sck  = sck_q;
   assign o_rx_data  = rx_data_q;
   assign o_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: free-running divider model, mode-0 slave model and frame-level checks.
module tb_spi_master_ctrl;

   localparam int W = 8;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_clk_div = 1'b0;
   logic [W-1:0] tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         cs_n, sck, mosi, miso;

   int checks = 0;
   int errors = 0;

   int n_div   = 4;
   int div_cnt = 0;

   bit           loopback = 1'b1;
   logic [W-1:0] slave_word = '0;
   logic         slave_bit = 1'b0;
   int           slave_idx = 0;

   int           cyc = 0, rises = 0, cs_low = 0, mosi_zero = 0, mosi_unstable = 0, rxv_bad = 0;
   logic [W-1:0] mosi_seq = '0;
   logic [W-1:0] rxq[$];
   int           rise_cyc[$];
   bit           sck_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0;

   spi_master_ctrl #(.P_DATA_WIDTH(W), .P_CNT_W(4)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clk_div  (i_clk_div),
      .i_tx_data  (tx_data),
      .i_tx_valid (tx_valid),
      .o_tx_ready (tx_ready),
      .o_rx_data  (rx_data),
      .o_rx_valid (rx_valid),
      .o_spi_cs_n (cs_n),
      .o_spi_sck  (sck),
      .o_spi_mosi (mosi),
      .i_spi_miso (miso)
   );

   always #5 i_clk = ~i_clk;

   // Registered divider: high for the first half of each period of n_div cycles.
   always @(posedge i_clk) begin
      div_cnt   <= (div_cnt + 1) % n_div;
      i_clk_div <= (((div_cnt + 1) % n_div) < (n_div / 2));
   end

   assign miso = loopback ? mosi : slave_bit;

   // Monitor and mode-0 slave: first bit out at CS fall, next bit after every SCK fall.
   always @(posedge i_clk) begin
      #1;
      cyc++;
      if (!cs_n) begin
         cs_low++;
         if (!mosi) mosi_zero++;
      end
      if (sck && !sck_prev) begin
         rises++;
         mosi_seq = {mosi_seq[W-2:0], mosi};
         if (mosi !== mosi_prev) mosi_unstable++;
         rise_cyc.push_back(cyc);
      end
      if (!sck && sck_prev && slave_idx > 0) begin
         slave_idx--;
         slave_bit = slave_word[slave_idx];
      end
      if (!cs_n && cs_prev) begin
         slave_idx = W - 1;
         slave_bit = slave_word[W-1];
      end
      if (rx_valid) begin
         rxq.push_back(rx_data);
         if (!(cs_n && tx_ready)) rxv_bad++;
      end
      sck_prev  = sck;
      cs_prev   = cs_n;
      mosi_prev = mosi;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      rises = 0; cs_low = 0; mosi_zero = 0; mosi_unstable = 0; rxv_bad = 0;
      mosi_seq = '0;
      rxq.delete();
      rise_cyc.delete();
   endtask

   task automatic settle();
      repeat (20) @(negedge i_clk);
   endtask

   task automatic wait_rx(input int n);
      int t = 0;
      while (rxq.size() < n && t < 40 * n_div + 100) begin
         @(negedge i_clk);
         t++;
      end
   endtask

   // One complete frame, checked against the rules: expected word, SCK count/spacing, CS window.
   task automatic run_frame(input logic [W-1:0] d, input bit lb, input logic [W-1:0] sw,
                            input string tag);
      int lo, hi, bad;
      logic [W-1:0] exp_rx;
      @(negedge i_clk);
      clear_mon();
      loopback = lb; slave_word = sw; tx_data = d; tx_valid = 1'b1;
      check({tag, "_ready_idle"}, tx_ready, 1);
      @(negedge i_clk);
      tx_valid = 1'b0;
      check({tag, "_cs_low_after_accept"}, cs_n, 0);
      check({tag, "_ready_busy"}, tx_ready, 0);
      repeat (4) @(negedge i_clk);
      tx_data = ~d; tx_valid = 1'b1;
      @(negedge i_clk);
      tx_valid = 1'b0;
      wait_rx(1);
      repeat (3) @(negedge i_clk);
      exp_rx = lb ? d : sw;
      lo = W * n_div + n_div / 2 + 1;
      hi = W * n_div + 3 * n_div / 2;
      bad = 0;
      for (int i = 1; i < rise_cyc.size(); i++)
         if (rise_cyc[i] - rise_cyc[i-1] != n_div) bad++;
      check({tag, "_rx_pulses"}, rxq.size(), 1);
      check({tag, "_rx_data"}, (rxq.size() > 0) ? rxq[0] : 'x, exp_rx);
      check({tag, "_rx_with_cs_high"}, rxv_bad, 0);
      check({tag, "_sck_rises"}, rises, W);
      check({tag, "_sck_spacing"}, bad, 0);
      check({tag, "_mosi_bits"}, mosi_seq, d);
      check({tag, "_mosi_stable"}, mosi_unstable, 0);
      check({tag, "_cs_low_window"}, (cs_low >= lo && cs_low <= hi), 1);
      check({tag, "_cs_high_after"}, cs_n, 1);
   endtask

   initial begin
      int t, gap;
      i_rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
      #1;
      check("rst_cs_n", cs_n, 1);
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_ready", tx_ready, 1);
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("post_rst_ready", tx_ready, 1);

      n_div = 4; settle();
      run_frame(8'hA5, 1'b1, 8'h00, "a5_loop");
      run_frame(8'hFF, 1'b0, 8'h3C, "ff_slave");
      check("ff_mosi_always_one", mosi_zero, 0);

      // Back-to-back with valid held high.
      @(negedge i_clk);
      clear_mon();
      loopback = 1'b1; tx_data = 8'h01; tx_valid = 1'b1;
      @(negedge i_clk);
      tx_data = 8'h80;
      t = 0;
      while (!cs_n && t < 300) begin @(negedge i_clk); t++; end
      gap = 0;
      while (cs_n && t < 300) begin gap++; @(negedge i_clk); t++; end
      tx_valid = 1'b0;
      wait_rx(2);
      repeat (3) @(negedge i_clk);
      check("b2b_cs_gap", gap, 1);
      check("b2b_pulses", rxq.size(), 2);
      check("b2b_first", (rxq.size() > 0) ? rxq[0] : 'x, 8'h01);
      check("b2b_second", (rxq.size() > 1) ? rxq[1] : 'x, 8'h80);
      check("b2b_rx_with_cs_high", rxv_bad, 0);
      check("b2b_sck_rises", rises, 2 * W);

      n_div = 2; settle();
      run_frame(8'h5A, 1'b1, 8'h00, "n2_loop");

      // Reset after the third SCK rise.
      n_div = 4; settle();
      @(negedge i_clk);
      clear_mon();
      loopback = 1'b1; tx_data = 8'h96; tx_valid = 1'b1;
      @(negedge i_clk);
      tx_valid = 1'b0;
      t = 0;
      while (rises < 3 && t < 200) begin @(negedge i_clk); t++; end
      check("mid_third_rise", rises, 3);
      check("mid_sck_high", sck, 1);
      #3 i_rst = 1'b1;
      #1;
      check("mid_rst_cs_n", cs_n, 1);
      check("mid_rst_sck", sck, 0);
      check("mid_rst_rx_valid", rx_valid, 0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      check("mid_rst_ready", tx_ready, 1);
      check("mid_rst_no_pulse", rxq.size(), 0);
      run_frame(8'hC3, 1'b1, 8'h00, "after_rst");

      for (int i = 0; i < 8; i++) begin
         n_div = 2 * $urandom_range(1, 4);
         settle();
         repeat ($urandom_range(0, 7)) @(negedge i_clk);
         run_frame(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
